// File: rtl/pwm_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timer_core
//  Description : PWM waveform and timer-interrupt generator. It is driven by
//                the free-running main_counter value and owns the glitch-free
//                duty shadow register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_timer_core #(
    parameter int CNT_W = 16
) (
    input  logic             slow_clk,
    input  logic             rst,
    input  logic             sw_rst,
    input  logic             counter_en,
    input  logic             mode,
    input  logic             timer_mode,
    input  logic             o_pwm_en,
    input  logic             irq_clr,
    input  logic [CNT_W-1:0] counter,
    input  logic [CNT_W-1:0] period_reg,
    input  logic [CNT_W-1:0] duty_reg,
    output logic             o_pwm,
    output logic             irq,
    output logic             irq_rst,
    output logic [CNT_W-1:0] duty_active
);

    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic             r_sw_rst_sync;
    logic             r_counter_en_sync;
    logic             r_mode_sync;
    logic             r_timer_mode_sync;
    logic             r_pwm_en_sync;
    logic [CNT_W-1:0] r_period_sync;
    logic [CNT_W-1:0] r_duty_sync;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pwm;
    logic             r_irq;
    logic             r_irq_rst;
    logic [CNT_W-1:0] r_duty_active;

    logic             w_event;
    logic             w_rearm;
    logic             w_duty_load;

    // Software reset is sampled on its own so it keeps tracking the input while it clears everything else.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_sw_rst_sync <= 1'b0;
        end else begin
            r_sw_rst_sync <= sw_rst;
        end
    end

    // One register stage on control and configuration inputs.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_counter_en_sync <= 1'b0;
            r_mode_sync       <= 1'b0;
            r_timer_mode_sync <= 1'b0;
            r_pwm_en_sync     <= 1'b0;
            r_period_sync     <= C_ZERO;
            r_duty_sync       <= C_ZERO;
        end else if (r_sw_rst_sync) begin
            r_counter_en_sync <= 1'b0;
            r_mode_sync       <= 1'b0;
            r_timer_mode_sync <= 1'b0;
            r_pwm_en_sync     <= 1'b0;
            r_period_sync     <= C_ZERO;
            r_duty_sync       <= C_ZERO;
        end else begin
            r_counter_en_sync <= counter_en;
            r_mode_sync       <= mode;
            r_timer_mode_sync <= timer_mode;
            r_pwm_en_sync     <= o_pwm_en;
            r_period_sync     <= period_reg;
            r_duty_sync       <= duty_reg;
        end
    end

    // A timer event needs an armed RUN state, a running counter and a non-zero period.
    assign w_event = (r_state == S_RUN) && r_counter_en_sync && !r_mode_sync &&
                     (r_period_sync != C_ZERO) && (counter == r_period_sync);

    // A clear in DONE re-arms main_counter through a single low cycle on irq_rst.
    assign w_rearm = (r_state == S_DONE) && r_counter_en_sync && !r_mode_sync && irq_clr;

    // The shadow only moves at the PWM wrap point, or freely when PWM output is not in use.
    assign w_duty_load = !r_counter_en_sync || !r_mode_sync || (r_period_sync == C_ZERO) ||
                         (counter == (r_period_sync - C_ONE));

    // Timer FSM next-state logic; PWM mode always parks the FSM in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (r_mode_sync) begin
            w_state_nxt = S_IDLE;
        end else if (r_counter_en_sync) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   if (w_event && !r_timer_mode_sync) w_state_nxt = S_DONE;
                S_DONE:  if (irq_clr) w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Timer FSM state register.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (r_sw_rst_sync) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sticky interrupt: an event beats a simultaneous clear; a stopped counter freezes it.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if (r_sw_rst_sync) begin
            r_irq <= 1'b0;
        end else if (w_event) begin
            r_irq <= 1'b1;
        end else if (irq_clr && r_counter_en_sync) begin
            r_irq <= 1'b0;
        end
    end

    // Active-low re-arm strobe towards main_counter.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_irq_rst <= 1'b1;
        end else if (r_sw_rst_sync) begin
            r_irq_rst <= 1'b1;
        end else begin
            r_irq_rst <= !w_rearm;
        end
    end

    // Duty shadow register.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_duty_active <= C_ZERO;
        end else if (r_sw_rst_sync) begin
            r_duty_active <= C_ZERO;
        end else if (w_duty_load) begin
            r_duty_active <= r_duty_sync;
        end
    end

    // Registered PWM compare; holds its value while the counter is stopped.
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= 1'b0;
        end else if (r_sw_rst_sync) begin
            r_pwm <= 1'b0;
        end else if (!r_mode_sync) begin
            r_pwm <= 1'b0;
        end else if (r_counter_en_sync) begin
            r_pwm <= r_pwm_en_sync && (counter < r_duty_active);
        end
    end

    // Gating with the synced mode drops the output in the same cycle timer mode takes over.
    assign o_pwm       = r_pwm && r_mode_sync;
    assign irq         = r_irq;
    assign irq_rst     = r_irq_rst;
    assign duty_active = r_duty_active;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_timer_core
//  Description : Scoreboard bench for pwm_timer_core. Stimulus queues the
//                hand-derived response; a monitor pops and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_timer_core;

    localparam int CNT_W = 16;

    logic             slow_clk = 1'b0;
    logic             rst = 1'b0;
    logic             sw_rst = 1'b0;
    logic             counter_en = 1'b0;
    logic             mode = 1'b0;
    logic             timer_mode = 1'b0;
    logic             o_pwm_en = 1'b0;
    logic             irq_clr = 1'b0;
    logic [CNT_W-1:0] counter = '0;
    logic [CNT_W-1:0] period_reg = '0;
    logic [CNT_W-1:0] duty_reg = '0;
    logic             o_pwm;
    logic             irq;
    logic             irq_rst;
    logic [CNT_W-1:0] duty_active;

    typedef struct {
        int               due;
        string            name;
        logic [3:0]       m;      // [0] o_pwm [1] irq [2] irq_rst [3] duty_active
        logic             pwm;
        logic             irq;
        logic             irst;
        logic [CNT_W-1:0] duty;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    event ev_async;

    pwm_timer_core #(.CNT_W(CNT_W)) dut (
        .slow_clk    (slow_clk),
        .rst         (rst),
        .sw_rst      (sw_rst),
        .counter_en  (counter_en),
        .mode        (mode),
        .timer_mode  (timer_mode),
        .o_pwm_en    (o_pwm_en),
        .irq_clr     (irq_clr),
        .counter     (counter),
        .period_reg  (period_reg),
        .duty_reg    (duty_reg),
        .o_pwm       (o_pwm),
        .irq         (irq),
        .irq_rst     (irq_rst),
        .duty_active (duty_active)
    );

    always #5 slow_clk = ~slow_clk;

    always @(posedge slow_clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation that has come due.
    initial begin
        exp_t e;
        forever begin
            @(negedge slow_clk or ev_async);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                vectors++;
                if ((e.m[0] && o_pwm !== e.pwm) || (e.m[1] && irq !== e.irq) ||
                    (e.m[2] && irq_rst !== e.irst) || (e.m[3] && duty_active !== e.duty)) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d: got pwm=%b irq=%b irq_rst=%b duty=%0d, want pwm=%b irq=%b irq_rst=%b duty=%0d (mask %b)",
                             e.name, cyc, o_pwm, irq, irq_rst, duty_active,
                             e.pwm, e.irq, e.irst, e.duty, e.m);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic exp_push(input int due, input string nm, input logic [3:0] m,
                            input logic p, input logic i, input logic r,
                            input logic [CNT_W-1:0] d);
        exp_t e;
        e.due = due; e.name = nm; e.m = m;
        e.pwm = p; e.irq = i; e.irst = r; e.duty = d;
        q.push_back(e);
    endtask

    // Program period/duty, let the shadow load at the wrap point, then run one period.
    task automatic pwm_run(input int per, input int dty, input logic en, input string nm);
        period_reg = CNT_W'(per);
        duty_reg   = CNT_W'(dty);
        o_pwm_en   = en;
        counter    = CNT_W'(per - 1);
        repeat (3) tick();
        for (int c = 0; c < per; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, nm, 4'b1001, en && (c < dty), 1'b0, 1'b1, CNT_W'(dty));
            tick();
        end
    endtask

    initial begin
        // Reset state
        tick();
        exp_push(cyc, "reset", 4'b1111, 1'b0, 1'b0, 1'b1, '0);
        tick();
        rst = 1'b1;

        // 1: PWM period 10, duty 3
        mode = 1'b1; counter_en = 1'b1; timer_mode = 1'b0;
        pwm_run(10, 3, 1'b1, "pwm_p10_d3");

        // 2: duty 3 -> 7 mid-period, shadow switches at counter 9
        for (int c = 0; c < 10; c++) begin
            counter = CNT_W'(c);
            if (c == 4) duty_reg = CNT_W'(7);
            exp_push(cyc + 1, "duty_hold", 4'b1001, (c < 3), 1'b0, 1'b1,
                     (c == 9) ? CNT_W'(7) : CNT_W'(3));
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "duty_new", 4'b1001, (c < 7), 1'b0, 1'b1, CNT_W'(7));
            tick();
        end

        // 3: duty edge cases at period 8
        pwm_run(8, 0, 1'b1, "duty0");
        pwm_run(8, 8, 1'b0, "pwm_en0");
        pwm_run(8, 8, 1'b1, "duty_eq_per");
        pwm_run(8, 20, 1'b1, "duty_gt_per");

        // 4: switch to continuous timer, period 5; o_pwm drops as mode_sync falls
        exp_push(cyc, "pwm_before_mode", 4'b0001, 1'b1, 1'b0, 1'b1, '0);
        mode = 1'b0; timer_mode = 1'b1; period_reg = CNT_W'(5); counter = '0;
        exp_push(cyc + 1, "mode_to_timer", 4'b0001, 1'b0, 1'b0, 1'b1, '0);
        repeat (3) tick();
        for (int c = 0; c <= 5; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "cont_ev1", 4'b0111, 1'b0, (c == 5), 1'b1, '0);
            tick();
        end
        counter = '0; irq_clr = 1'b1;
        exp_push(cyc + 1, "cont_clr", 4'b0110, 1'b0, 1'b0, 1'b1, '0);
        tick();
        irq_clr = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "cont_ev2", 4'b0110, 1'b0, (c == 5), 1'b1, '0);
            tick();
        end

        // 5: one-shot, period 4
        timer_mode = 1'b0; period_reg = CNT_W'(4); counter = '0; irq_clr = 1'b1;
        exp_push(cyc + 1, "os_preclr", 4'b0110, 1'b0, 1'b0, 1'b1, '0);
        tick();
        irq_clr = 1'b0;
        repeat (2) tick();
        for (int c = 0; c <= 4; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "os_ev", 4'b0110, 1'b0, (c == 4), 1'b1, '0);
            tick();
        end
        for (int c = 0; c <= 4; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "os_done", 4'b0110, 1'b0, 1'b1, 1'b1, '0);
            tick();
        end
        counter = '0; irq_clr = 1'b1;
        exp_push(cyc + 1, "os_rearm", 4'b0110, 1'b0, 1'b0, 1'b0, '0);
        tick();
        irq_clr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "os_ev2", 4'b0110, 1'b0, (c == 4), 1'b1, '0);
            tick();
        end

        // 6a: re-arm into continuous, then clear coincident with an event
        counter = '0; irq_clr = 1'b1; timer_mode = 1'b1;
        exp_push(cyc + 1, "os_rearm2", 4'b0110, 1'b0, 1'b0, 1'b0, '0);
        tick();
        irq_clr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            counter = CNT_W'(c);
            irq_clr = (c == 4);
            exp_push(cyc + 1, "clr_vs_event", 4'b0110, 1'b0, (c == 4), 1'b1, '0);
            tick();
        end
        irq_clr = 1'b0;
        counter = '0; irq_clr = 1'b1;
        exp_push(cyc + 1, "run_clr", 4'b0110, 1'b0, 1'b0, 1'b1, '0);
        tick();
        irq_clr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            counter = CNT_W'(c);
            exp_push(cyc + 1, "run_ev", 4'b0110, 1'b0, (c == 4), 1'b1, '0);
            tick();
        end

        // 6b: back to PWM high (irq retained), then asynchronous reset
        mode = 1'b1; o_pwm_en = 1'b1; period_reg = CNT_W'(8); duty_reg = CNT_W'(20);
        counter = CNT_W'(7);
        repeat (3) tick();
        exp_push(cyc, "pwm_high_pre_rst", 4'b1011, 1'b1, 1'b1, 1'b1, CNT_W'(20));
        @(negedge slow_clk);
        #1;
        rst = 1'b0;
        #1;
        exp_push(cyc, "async_rst", 4'b1111, 1'b0, 1'b0, 1'b1, '0);
        ->ev_async;
        tick();
        rst = 1'b1;

        // Synchronous software reset from PWM high
        repeat (3) tick();
        exp_push(cyc, "pwm_high_pre_sw", 4'b1011, 1'b1, 1'b0, 1'b1, CNT_W'(20));
        sw_rst = 1'b1;
        exp_push(cyc + 1, "sw_rst_lag", 4'b0001, 1'b1, 1'b0, 1'b1, '0);
        tick();
        exp_push(cyc + 1, "sw_rst", 4'b1111, 1'b0, 1'b0, 1'b1, '0);
        tick();
        sw_rst = 1'b0;
        repeat (3) tick();

        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
